// File: rtl/log_trace_arbiter.sv
// log_trace_arbiter: filters per-source log requests, round-robin grants one per cycle into a cycle-stamped record FIFO
module log_trace_arbiter #(
  parameter int SRC_NUM    = 4,
  parameter int DATA_WIDTH = 64,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic                                         cfg_en,
  input  logic [1:0]                                   cfg_level,
  input  logic                                         cfg_addr_en,
  input  logic [31:0]                                  cfg_addr,
  input  logic [SRC_NUM-1:0]                           src_valid,
  output logic [SRC_NUM-1:0]                           src_ready,
  input  logic [2*SRC_NUM-1:0]                         src_level,
  input  logic [32*SRC_NUM-1:0]                        src_addr,
  input  logic [DATA_WIDTH*SRC_NUM-1:0]                src_data,
  output logic                                         out_valid,
  input  logic                                         out_ready,
  output logic [(SRC_NUM > 1 ? $clog2(SRC_NUM) : 1)-1:0] out_src,
  output logic [1:0]                                   out_level,
  output logic [63:0]                                  out_cycle,
  output logic [DATA_WIDTH-1:0]                        out_data,
  output logic [63:0]                                  cycle_cnt,
  output logic [31:0]                                  filt_cnt
);
  localparam int SW = SRC_NUM > 1 ? $clog2(SRC_NUM) : 1;
  localparam int AW = $clog2(FIFO_DEPTH);

  logic [SRC_NUM-1:0] passMask, dropMask, reqMask, grantMask;
  logic [SW-1:0] rrPtr, grantIdx;
  logic found, full, push, pop;
  logic [AW:0] count;
  logic [AW-1:0] wrPtr, rdPtr;
  logic [31:0] dropCnt;
  logic [32:0] filtSum;
  logic [SW-1:0] srcMem [FIFO_DEPTH];
  logic [1:0] lvlMem [FIFO_DEPTH];
  logic [63:0] cycMem [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] dataMem [FIFO_DEPTH];

  function automatic logic [SW-1:0] wrapIdx(input int v);
    return SW'(v >= SRC_NUM ? v - SRC_NUM : v);
  endfunction

  // filter every source against the live configuration
  always_comb begin
    passMask = '0;
    for (int i = 0; i < SRC_NUM; i++)
      passMask[i] = cfg_en && src_level[2*i +: 2] >= cfg_level && (!cfg_addr_en || src_addr[32*i +: 32] == cfg_addr);
  end

  assign dropMask  = rst ? '0 : src_valid & ~passMask;
  assign reqMask   = rst ? '0 : src_valid & passMask;
  assign full      = count == (AW+1)'(FIFO_DEPTH);
  assign push      = found && !full;
  assign grantMask = push ? SRC_NUM'(1) << grantIdx : '0;
  assign src_ready = dropMask | grantMask;
  assign out_valid = count != '0;
  assign pop       = out_valid && out_ready;
  assign out_src   = srcMem[rdPtr];
  assign out_level = lvlMem[rdPtr];
  assign out_cycle = cycMem[rdPtr];
  assign out_data  = dataMem[rdPtr];

  // first passing requester at or after rrPtr, wrapping
  always_comb begin
    found = 1'b0;
    grantIdx = '0;
    for (int k = 0; k < SRC_NUM; k++)
      if (!found && reqMask[wrapIdx(int'(rrPtr) + k)]) begin
        found = 1'b1;
        grantIdx = wrapIdx(int'(rrPtr) + k);
      end
  end

  // number of discarded requests this cycle, merged into the saturating total
  always_comb begin
    dropCnt = '0;
    for (int i = 0; i < SRC_NUM; i++) dropCnt = dropCnt + 32'(dropMask[i]);
    filtSum = {1'b0, filt_cnt} + {1'b0, dropCnt};
  end

  // counters, arbitration pointer and FIFO occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_cnt <= '0;
      filt_cnt <= '0;
      rrPtr <= '0;
      count <= '0;
      wrPtr <= '0;
      rdPtr <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + 64'd1;
      filt_cnt <= filtSum[32] ? '1 : filtSum[31:0];
      if (push) begin
        rrPtr <= wrapIdx(int'(grantIdx) + 1);
        wrPtr <= wrPtr + AW'(1);
      end
      if (pop) rdPtr <= rdPtr + AW'(1);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

  // capture the granted record with the stamp of its grant cycle
  always_ff @(posedge clk) begin
    if (push) begin
      srcMem[wrPtr] <= grantIdx;
      lvlMem[wrPtr] <= src_level[2*grantIdx +: 2];
      cycMem[wrPtr] <= cycle_cnt;
      dataMem[wrPtr] <= src_data[DATA_WIDTH*grantIdx +: DATA_WIDTH];
    end
  end
endmodule

// File: tb/tb_log_trace_arbiter.sv
// tb_log_trace_arbiter: directed stimulus with a queue-based reference model checked every cycle
module tb_log_trace_arbiter;
  logic clk = 0, rst = 1, cfg_en = 0, cfg_addr_en = 0, out_ready = 1;
  logic [1:0] cfg_level = 0;
  logic [31:0] cfg_addr = 0;
  logic [3:0] src_valid = 0, src_ready;
  logic [7:0] src_level = 0;
  logic [127:0] src_addr = 0;
  logic [255:0] src_data = 0;
  logic out_valid;
  logic [1:0] out_src, out_level;
  logic [63:0] out_cycle, out_data, cycle_cnt;
  logic [31:0] filt_cnt, f0;
  int passed = 0, total = 0;

  log_trace_arbiter dut (
    .clk(clk), .rst(rst), .cfg_en(cfg_en), .cfg_level(cfg_level),
    .cfg_addr_en(cfg_addr_en), .cfg_addr(cfg_addr),
    .src_valid(src_valid), .src_ready(src_ready), .src_level(src_level),
    .src_addr(src_addr), .src_data(src_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_src(out_src),
    .out_level(out_level), .out_cycle(out_cycle), .out_data(out_data),
    .cycle_cnt(cycle_cnt), .filt_cnt(filt_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  typedef struct {
    int src;
    logic [1:0] lvl;
    logic [63:0] cyc;
    logic [63:0] data;
  } rec_t;

  rec_t q[$];
  int mRr = 0;
  logic [63:0] mCyc = 0;
  logic [31:0] mFilt = 0;
  bit synced = 0;

  // reference model: evaluate the cycle from current inputs, compare, then advance to the next edge
  always @(negedge clk) begin : model
    logic [3:0] pass, expReady;
    int g;
    longint f;
    pass = 0;
    expReady = 0;
    g = -1;
    if (!rst) begin
      for (int i = 0; i < 4; i++)
        pass[i] = cfg_en && src_level[2*i +: 2] >= cfg_level && (!cfg_addr_en || src_addr[32*i +: 32] == cfg_addr);
      if (q.size() < 8)
        for (int k = 0; k < 4; k++)
          if (g < 0 && src_valid[(mRr + k) % 4] && pass[(mRr + k) % 4]) g = (mRr + k) % 4;
      expReady = src_valid & ~pass;
      if (g >= 0) expReady[g] = 1'b1;
    end
    if (synced) begin
      chk("src_ready", src_ready, expReady);
      chk("out_valid", out_valid, q.size() > 0);
      if (q.size() > 0) begin
        chk("out_src", out_src, q[0].src);
        chk("out_level", out_level, q[0].lvl);
        chk("out_cycle", out_cycle, q[0].cyc);
        chk("out_data", out_data, q[0].data);
      end
      chk("cycle_cnt", cycle_cnt, mCyc);
      chk("filt_cnt", filt_cnt, mFilt);
    end
    if (rst) begin
      q.delete();
      mRr = 0;
      mCyc = 0;
      mFilt = 0;
      synced = 1;
    end else begin
      if (q.size() > 0 && out_ready) void'(q.pop_front());
      if (g >= 0) begin
        q.push_back('{g, src_level[2*g +: 2], mCyc, src_data[64*g +: 64]});
        mRr = (g + 1) % 4;
      end
      f = longint'(mFilt) + longint'($countones(src_valid & ~pass));
      mFilt = f > 64'hFFFFFFFF ? 32'hFFFFFFFF : f[31:0];
      mCyc++;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic setSrc(int i, logic [1:0] l, logic [31:0] a, logic [63:0] d);
    src_level[2*i +: 2] = l;
    src_addr[32*i +: 32] = a;
    src_data[64*i +: 64] = d;
  endtask

  initial begin
    cyc();
    cyc();
    rst = 0;
    chk("reset cycle_cnt", cycle_cnt, 0);
    chk("reset out_valid", out_valid, 0);
    chk("reset filt_cnt", filt_cnt, 0);

    cfg_en = 1;
    repeat (10) cyc();
    setSrc(0, 1, 0, 64'hA5);
    src_valid = 4'b0001;
    #1 chk("single ready", src_ready, 4'b0001);
    cyc();
    src_valid = 0;
    chk("single out_valid", out_valid, 1);
    chk("single out_src", out_src, 0);
    chk("single out_cycle", out_cycle, 10);
    chk("single out_data", out_data, 64'hA5);

    rst = 1;
    cyc();
    rst = 0;
    for (int i = 0; i < 4; i++) setSrc(i, 3, 0, 64'h100 + i);
    for (int k = 0; k < 5; k++) begin
      src_valid = 4'hF;
      #1 chk("rr grant", src_ready, 4'b1 << (k % 4));
      if (k > 0) chk("rr out_src", out_src, (k - 1) % 4);
      cyc();
    end
    src_valid = 0;
    chk("rr last out_src", out_src, 0);
    cyc();

    cfg_level = 2;
    setSrc(1, 1, 0, 64'h11);
    setSrc(2, 3, 0, 64'h22);
    src_valid = 4'b0110;
    #1 chk("level ready", src_ready, 4'b0110);
    f0 = filt_cnt;
    cyc();
    src_valid = 0;
    chk("level filt", filt_cnt, f0 + 1);
    chk("level out_src", out_src, 2);
    chk("level out_data", out_data, 64'h22);
    cyc();

    cfg_level = 0;
    out_ready = 0;
    src_valid = 4'b0001;
    for (int k = 0; k < 8; k++) begin
      setSrc(0, 0, 0, k);
      #1 chk("fill ready", src_ready[0], 1);
      cyc();
    end
    #1 chk("full ready", src_ready[0], 0);
    chk("full head data", out_data, 0);
    cyc();
    out_ready = 1;
    #1 chk("full pop no push", src_ready[0], 0);
    cyc();
    #1 chk("pop then push", src_ready[0], 1);
    cyc();
    src_valid = 0;
    repeat (10) cyc();

    cfg_addr_en = 1;
    cfg_addr = 32'h814548C0;
    setSrc(3, 0, 32'h814548C0, 64'h33);
    setSrc(0, 0, 0, 64'h44);
    src_valid = 4'b1001;
    #1 chk("addr ready", src_ready, 4'b1001);
    f0 = filt_cnt;
    cyc();
    src_valid = 0;
    cfg_addr_en = 0;
    chk("addr filt", filt_cnt, f0 + 1);
    chk("addr out_src", out_src, 3);
    cyc();

    out_ready = 0;
    setSrc(1, 2, 0, 64'h77);
    src_valid = 4'b0010;
    repeat (5) cyc();
    src_valid = 0;
    #1 chk("pre-reset out_valid", out_valid, 1);
    rst = 1;
    src_valid = 4'hF;
    #1 chk("reset ready", src_ready, 0);
    cyc();
    rst = 0;
    #1 chk("post-reset out_valid", out_valid, 0);
    chk("post-reset cycle_cnt", cycle_cnt, 0);
    chk("post-reset filt_cnt", filt_cnt, 0);
    chk("post-reset grant", src_ready, 4'b0001);
    cyc();
    src_valid = 0;
    out_ready = 1;
    repeat (3) cyc();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
